match_tally: RTL and testbench

Downstream consumer of the sequence-detector stage. It takes that stage's 1-bit match flag ("ans": high while the 1→2→3 sequence has just completed) and counts distinct match events. The count saturates, raises a sticky threshold alarm, and is returned to a host through a req/ack snapshot handshake. It sits between the detector and the host/debug readout logic.

---
 rtl/match_pkg.sv | 13 +
 rtl/match_edge_det.sv | 21 ++
 rtl/match_tally.sv | 151 +++++++++++++++
 tb/tb_match_tally.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// Shared types and defaults for the match_tally event counter.
package match_pkg;

  localparam int unsigned CntWDefault   = 8;
  localparam int unsigned ThreshDefault = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHold = 2'd1,
    StDrop = 2'd2
  } rd_state_e;

endpackage

// File: rtl/match_edge_det.sv
// Registered rising-edge detector: ev is high for one cycle per low-to-high transition.
module match_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic match_in,
  output logic ev
);

  logic r_match_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_match_q <= 1'b0;
    end else begin
      r_match_q <= match_in;
    end
  end

  assign ev = match_in & ~r_match_q;

endmodule

// File: rtl/match_tally.sv
// Counts distinct detector match events with saturation, sticky alarm and req/ack snapshot.
// Optional inter-event gap measurement is enabled by defining GAP_MEASURE_EN.
module match_tally
  import match_pkg::*;
#(
  parameter int unsigned CNT_W  = CntWDefault,
  parameter int unsigned THRESH = ThreshDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             match_in,
  input  logic             clr,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic [CNT_W-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             sat,
  output logic             alarm
`ifdef GAP_MEASURE_EN
  ,
  output logic [CNT_W-1:0] last_gap,
  output logic             gap_valid
`endif
);

  localparam logic [CNT_W-1:0] AllOnes   = '1;
  localparam logic [CNT_W-1:0] ThreshVal = CNT_W'(THRESH);

  logic             w_ev;
  logic             w_sat;
  logic [CNT_W-1:0] r_count;
  logic             r_alarm;

  match_edge_det u_edge_det (
    .clk      (clk),
    .rst_n    (rst_n),
    .match_in (match_in),
    .ev       (w_ev)
  );

  assign w_sat = (r_count == AllOnes);

  // Alarm looks at the registered count, so it lands one cycle after the threshold is crossed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_alarm <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_alarm <= 1'b0;
    end else begin
      if (w_ev && !w_sat) begin
        r_count <= r_count + CNT_W'(1);
      end
      if (r_count >= ThreshVal) begin
        r_alarm <= 1'b1;
      end
    end
  end

  rd_state_e        r_state;
  rd_state_e        w_state_d;
  logic             r_rd_ack;
  logic             w_rd_ack_d;
  logic             w_snap;
  logic [CNT_W-1:0] r_rd_data;

  always_comb begin
    w_state_d  = r_state;
    w_rd_ack_d = r_rd_ack;
    w_snap     = 1'b0;
    case (r_state)
      StIdle: begin
        if (rd_req) begin
          w_state_d  = StHold;
          w_rd_ack_d = 1'b1;
          w_snap     = 1'b1;
        end
      end
      StHold: begin
        if (!rd_req) begin
          w_state_d  = StDrop;
          w_rd_ack_d = 1'b0;
        end
      end
      StDrop: begin
        w_state_d  = StIdle;
        w_rd_ack_d = 1'b0;
      end
      default: begin
        w_state_d  = StIdle;
        w_rd_ack_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_rd_ack  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_state  <= w_state_d;
      r_rd_ack <= w_rd_ack_d;
      if (w_snap) begin
        r_rd_data <= r_count;
      end
    end
  end

  assign count   = r_count;
  assign sat     = w_sat;
  assign alarm   = r_alarm;
  assign rd_ack  = r_rd_ack;
  assign rd_data = r_rd_data;

`ifdef GAP_MEASURE_EN
  logic [CNT_W-1:0] r_gap_cnt;
  logic [CNT_W-1:0] r_last_gap;
  logic             r_gap_valid;
  logic             r_gap_armed;

  // The first event after reset/clr only arms the measurement; no gap is reported yet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap_cnt   <= '0;
      r_last_gap  <= '0;
      r_gap_valid <= 1'b0;
      r_gap_armed <= 1'b0;
    end else if (clr) begin
      r_gap_cnt   <= '0;
      r_last_gap  <= '0;
      r_gap_valid <= 1'b0;
      r_gap_armed <= 1'b0;
    end else if (w_ev) begin
      r_gap_cnt   <= '0;
      r_gap_armed <= 1'b1;
      if (r_gap_armed) begin
        r_last_gap  <= (r_gap_cnt == AllOnes) ? AllOnes : r_gap_cnt + CNT_W'(1);
        r_gap_valid <= 1'b1;
      end
    end else if (r_gap_cnt != AllOnes) begin
      r_gap_cnt <= r_gap_cnt + CNT_W'(1);
    end
  end

  assign last_gap  = r_last_gap;
  assign gap_valid = r_gap_valid;
`endif

endmodule

// File: tb/tb_match_tally.sv
// Directed self-checking bench for match_tally; gap checks run when GAP_MEASURE_EN is defined.
module tb_match_tally;

  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             match_in;
  logic             clr;
  logic             rd_req;
  logic             rd_ack;
  logic [CNT_W-1:0] rd_data;
  logic [CNT_W-1:0] count;
  logic             sat;
  logic             alarm;
`ifdef GAP_MEASURE_EN
  logic [CNT_W-1:0] last_gap;
  logic             gap_valid;
`endif

  int vectors;
  int miscompares;

  match_tally #(
    .CNT_W  (CNT_W),
    .THRESH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .match_in  (match_in),
    .clr       (clr),
    .rd_req    (rd_req),
    .rd_ack    (rd_ack),
    .rd_data   (rd_data),
    .count     (count),
    .sat       (sat),
    .alarm     (alarm)
`ifdef GAP_MEASURE_EN
    ,
    .last_gap  (last_gap),
    .gap_valid (gap_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle match pulse followed by a number of low cycles.
  task automatic pulse(input int low_cycles);
    match_in = 1'b1;
    tick(1);
    match_in = 1'b0;
    tick(low_cycles);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    match_in = 1'b0;
    clr      = 1'b0;
    rd_req   = 1'b0;
    tick(2);
    vectors++;
    if ({count, sat, alarm, rd_ack, rd_data} !== {8'd0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_outputs: got count=%0d sat=%0b alarm=%0b ack=%0b data=%0d, want all 0",
               count, sat, alarm, rd_ack, rd_data);
    end
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_pulses();
    for (int i = 0; i < 3; i++) pulse(2);
    vectors++;
    if (count !== 8'd3 || alarm !== 1'b0) begin
      miscompares++;
      $display("FAIL three_pulses: got count=%0d alarm=%0b, want 3/0", count, alarm);
    end
    match_in = 1'b1;
    tick(1);
    match_in = 1'b0;
    vectors++;
    if (count !== 8'd4 || alarm !== 1'b0) begin
      miscompares++;
      $display("FAIL fourth_pulse: got count=%0d alarm=%0b, want 4/0", count, alarm);
    end
    tick(1);
    vectors++;
    if (alarm !== 1'b1) begin
      miscompares++;
      $display("FAIL alarm_delay: got alarm=%0b, want 1", alarm);
    end
  endtask

  task automatic test_hold_level();
    match_in = 1'b1;
    tick(10);
    match_in = 1'b0;
    tick(1);
    vectors++;
    if (count !== 8'd5) begin
      miscompares++;
      $display("FAIL held_level: got count=%0d, want 5", count);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 260; i++) pulse(1);
    vectors++;
    if (count !== 8'd255 || sat !== 1'b1 || alarm !== 1'b1) begin
      miscompares++;
      $display("FAIL saturate: got count=%0d sat=%0b alarm=%0b, want 255/1/1", count, sat, alarm);
    end
    do_clr();
    vectors++;
    if (count !== 8'd0 || sat !== 1'b0 || alarm !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_after_sat: got count=%0d sat=%0b alarm=%0b, want 0/0/0",
               count, sat, alarm);
    end
  endtask

  task automatic test_clr_priority();
    for (int i = 0; i < 5; i++) pulse(1);
    vectors++;
    if (count !== 8'd5) begin
      miscompares++;
      $display("FAIL clr_setup: got count=%0d, want 5", count);
    end
    match_in = 1'b1;
    clr      = 1'b1;
    tick(1);
    clr      = 1'b0;
    match_in = 1'b0;
    vectors++;
    if (count !== 8'd0) begin
      miscompares++;
      $display("FAIL clr_vs_ev: got count=%0d, want 0", count);
    end
    tick(1);
    vectors++;
    if (count !== 8'd0) begin
      miscompares++;
      $display("FAIL clr_vs_ev_after: got count=%0d, want 0", count);
    end
  endtask

  task automatic test_readout();
    for (int i = 0; i < 7; i++) pulse(1);
    match_in = 1'b1;
    rd_req   = 1'b1;
    tick(1);
    match_in = 1'b0;
    vectors++;
    if (rd_ack !== 1'b1 || rd_data !== 8'd7 || count !== 8'd8) begin
      miscompares++;
      $display("FAIL snapshot: got ack=%0b data=%0d count=%0d, want 1/7/8", rd_ack, rd_data, count);
    end
    tick(1);
    pulse(1);
    pulse(1);
    vectors++;
    if (rd_ack !== 1'b1 || rd_data !== 8'd7 || count !== 8'd10) begin
      miscompares++;
      $display("FAIL snapshot_hold: got ack=%0b data=%0d count=%0d, want 1/7/10",
               rd_ack, rd_data, count);
    end
    rd_req = 1'b0;
    tick(1);
    vectors++;
    if (rd_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_drop: got ack=%0b, want 0", rd_ack);
    end
    // Request raised during DROP must wait for IDLE before being served.
    rd_req = 1'b1;
    tick(1);
    vectors++;
    if (rd_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_gap: got ack=%0b, want 0", rd_ack);
    end
    tick(1);
    vectors++;
    if (rd_ack !== 1'b1 || rd_data !== 8'd10) begin
      miscompares++;
      $display("FAIL back_to_back: got ack=%0b data=%0d, want 1/10", rd_ack, rd_data);
    end
    rd_req = 1'b0;
    tick(3);
  endtask

  task automatic test_async_reset();
    do_clr();
    for (int i = 0; i < 9; i++) pulse(1);
    rd_req = 1'b1;
    tick(1);
    vectors++;
    if (rd_ack !== 1'b1 || rd_data !== 8'd9 || count !== 8'd9) begin
      miscompares++;
      $display("FAIL hold_setup: got ack=%0b data=%0d count=%0d, want 1/9/9", rd_ack, rd_data, count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (rd_ack !== 1'b0 || rd_data !== 8'd0 || count !== 8'd0 || alarm !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got ack=%0b data=%0d count=%0d alarm=%0b, want all 0",
               rd_ack, rd_data, count, alarm);
    end
    rd_req = 1'b0;
    #1;
    rst_n = 1'b1;
    tick(2);
  endtask

`ifdef GAP_MEASURE_EN
  task automatic test_gap();
    pulse(2);
    vectors++;
    if (gap_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL gap_first: got gap_valid=%0b, want 0", gap_valid);
    end
    pulse(6);
    vectors++;
    if (gap_valid !== 1'b1 || last_gap !== 8'd3) begin
      miscompares++;
      $display("FAIL gap_3: got valid=%0b last_gap=%0d, want 1/3", gap_valid, last_gap);
    end
    pulse(1);
    vectors++;
    if (gap_valid !== 1'b1 || last_gap !== 8'd7) begin
      miscompares++;
      $display("FAIL gap_7: got valid=%0b last_gap=%0d, want 1/7", gap_valid, last_gap);
    end
    do_clr();
    vectors++;
    if (gap_valid !== 1'b0 || last_gap !== 8'd0) begin
      miscompares++;
      $display("FAIL gap_clr: got valid=%0b last_gap=%0d, want 0/0", gap_valid, last_gap);
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_pulses();
    test_hold_level();
    test_saturate();
    test_clr_priority();
    test_readout();
    test_async_reset();
`ifdef GAP_MEASURE_EN
    test_gap();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
